// File: rtl/data_ram_ctrl.sv
// Load/store controller between EX and MEM: drives the data RAM over a req/ack
// handshake and returns aligned, extended load data. Optional watchdog: MEM_TIMEOUT_EN.
module data_ram_ctrl #(
  parameter int INSTR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   W_EX_mem_req,
  input  logic                   W_EX_mem_wr,
  input  logic [1:0]             W_EX_mem_size,
  input  logic                   W_EX_mem_sext,
  input  logic [INSTR_WIDTH-1:0] W_EX_alu_res,
  input  logic [INSTR_WIDTH-1:0] W_EX_rt_data,
  output logic                   W_ram_en,
  output logic [3:0]             W_ram_we,
  output logic [INSTR_WIDTH-1:0] W_ram_addr,
  output logic [INSTR_WIDTH-1:0] W_ram_w_data,
  input  logic                   W_ram_ack,
  input  logic [INSTR_WIDTH-1:0] W_ram_r_data,
  output logic [INSTR_WIDTH-1:0] W_data_ram_r_data,
  output logic                   W_mem_stall,
  output logic                   W_mem_done,
  output logic                   W_addr_err,
  output logic                   W_bus_err,
  output logic [1:0]             W_dbg_state
);

  // RAM handshake: W_ram_en rises with a registered request and stays high,
  // with address/data/enables stable, until the cycle W_ram_ack is sampled high.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_n;
  logic [1:0] addr_lo_q;
  logic [1:0] size_q;
  logic       sext_q;
  logic       wr_q;
  logic       misaligned;
  logic       accept;
  logic       timeout;
  logic [3:0] we_c;
  logic [INSTR_WIDTH-1:0] wdata_c;
  logic [INSTR_WIDTH-1:0] load_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign misaligned = ((W_EX_mem_size == 2'b01) && W_EX_alu_res[0]) ||
                      (W_EX_mem_size[1] && (W_EX_alu_res[1:0] != 2'b00));
  assign accept      = (state == IDLE) && W_EX_mem_req && !misaligned;
  assign W_dbg_state = state;

  always_comb begin
    we_c    = 4'b1111;
    wdata_c = W_EX_rt_data;
    case (W_EX_mem_size)
      2'b00: begin
        we_c    = 4'b0001 << W_EX_alu_res[1:0];
        wdata_c = {4{W_EX_rt_data[7:0]}};
      end
      2'b01: begin
        we_c    = 4'b0011 << W_EX_alu_res[1:0];
        wdata_c = {2{W_EX_rt_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = W_ram_r_data[8*addr_lo_q +: 8];
    lane_h = W_ram_r_data[16*addr_lo_q[1] +: 16];
    case (size_q)
      2'b00:   load_c = {{24{sext_q & lane_b[7]}}, lane_b};
      2'b01:   load_c = {{16{sext_q & lane_h[15]}}, lane_h};
      default: load_c = W_ram_r_data;
    endcase
  end

  always_comb begin
    state_n     = state;
    W_mem_stall = 1'b0;
    W_mem_done  = 1'b0;
    W_addr_err  = 1'b0;
    case (state)
      IDLE: begin
        if (W_EX_mem_req) begin
          if (misaligned) begin
            W_addr_err = 1'b1;
          end else begin
            W_mem_stall = 1'b1;
            state_n     = BUSY;
          end
        end
      end
      BUSY: begin
        W_mem_stall = 1'b1;
        if (W_ram_ack || timeout) state_n = DONE;
      end
      DONE: begin
        W_mem_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      addr_lo_q         <= '0;
      size_q            <= '0;
      sext_q            <= 1'b0;
      wr_q              <= 1'b0;
      W_ram_en          <= 1'b0;
      W_ram_we          <= '0;
      W_ram_addr        <= '0;
      W_ram_w_data      <= '0;
      W_data_ram_r_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_lo_q    <= W_EX_alu_res[1:0];
        size_q       <= W_EX_mem_size;
        sext_q       <= W_EX_mem_sext;
        wr_q         <= W_EX_mem_wr;
        W_ram_en     <= 1'b1;
        W_ram_we     <= W_EX_mem_wr ? we_c : 4'b0000;
        W_ram_addr   <= {2'b00, W_EX_alu_res[INSTR_WIDTH-1:2]};
        W_ram_w_data <= wdata_c;
      end else if (state == BUSY) begin
        if (W_ram_ack) begin
          W_ram_en <= 1'b0;
          W_ram_we <= '0;
          if (!wr_q) W_data_ram_r_data <= load_c;
        end else if (timeout) begin
          W_ram_en          <= 1'b0;
          W_ram_we          <= '0;
          W_data_ram_r_data <= '0;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             bus_err_q;

  assign timeout   = (state == BUSY) && !W_ram_ack &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign W_bus_err = bus_err_q;

  // The count clears whenever BUSY is left, by ack or by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state == BUSY) && !W_ram_ack && !timeout) wd_cnt <= wd_cnt + 1'b1;
      else                                           wd_cnt <= '0;
      bus_err_q <= timeout;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign W_bus_err      = 1'b0;
`endif

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
Load/store access controller between the EX stage and the MEM stage of the 5-stage MIPS pipeline.
- Takes the EX memory request (address = ALU result, store data = rt), drives the data RAM with a req/ack handshake, and returns aligned, extended load data on W_data_ram_r_data to MEM.
- Stalls the pipeline while an access is outstanding and flags misaligned addresses.

Parameters:
INSTR_WIDTH, 32, datapath/address width; only 32 supported.
TIMEOUT_CYCLES, 16, watchdog limit in BUSY cycles; used only with MEM_TIMEOUT_EN.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  asynchronous, active-high reset.
W_EX_mem_req  input  1  EX holds a load/store; held stable while W_mem_stall=1.
W_EX_mem_wr  input  1  1=store, 0=load.
W_EX_mem_size  input  2  00 byte, 01 half, 10/11 word.
W_EX_mem_sext  input  1  loads: 1 sign-extend, 0 zero-extend.
W_EX_alu_res  input  32  byte address.
W_EX_rt_data  input  32  store data.
W_ram_en  output  1  RAM request, held until ack.
W_ram_we  output  4  byte write enables, bit i = byte lane i.
W_ram_addr  output  32  word index {2'b00, addr[31:2]}.
W_ram_w_data  output  32  lane-replicated store data.
W_ram_ack  input  1  RAM completion; read data valid in the same cycle.
W_ram_r_data  input  32  raw RAM word.
W_data_ram_r_data  output  32  aligned/extended load result to MEM.
W_mem_stall  output  1  freeze PC, IF/ID and ID/EX/EX-MEM registers.
W_mem_done  output  1  one-cycle completion pulse.
W_addr_err  output  1  misaligned-request flag, combinational.
W_bus_err  output  1  watchdog abort pulse; constant 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, any state): state=IDLE. W_ram_en=0, W_ram_we=0, W_ram_addr=0, W_ram_w_data=0, W_data_ram_r_data=0, W_mem_done=0, W_bus_err=0, watchdog counter=0.
- FSM states: IDLE, BUSY, DONE.
- Misaligned request: half with addr[0]=1, or word with addr[1:0]!=0.
  - W_addr_err=1 combinationally while in IDLE.
  - No RAM access, no stall, state stays IDLE.
- IDLE, accepting a request (req=1 and aligned):
  - W_mem_stall=1 combinationally.
  - At the clock edge: latch addr, size, sext and wr; register W_ram_en=1, W_ram_addr, W_ram_we and W_ram_w_data; go to BUSY.
- Write enables and data, with offset o=addr[1:0]:
  - byte: we=0001<<o, data={4{rt[7:0]}}.
  - half: we=0011<<o, data={2{rt[15:0]}}.
  - word: we=1111, data=rt.
  - Loads: we=0000.
- BUSY:
  - W_mem_stall=1; W_ram_en and address/data held.
  - On W_ram_ack=1: W_ram_en->0, W_ram_we->0, go to DONE.
  - On a load, also register W_data_ram_r_data:
    - byte: lane o, extended per sext.
    - half: bits [16*addr[1]+15 : 16*addr[1]], extended per sext.
    - word: raw word.
  - On a store, W_data_ram_r_data is unchanged.
- DONE:
  - W_mem_stall=0, W_mem_done=1 for exactly this cycle; the pipeline advances at this edge.
  - Always returns to IDLE; a new request is accepted on the following cycle.
- Minimum latency: 3 cycles per access (IDLE, BUSY with ack, DONE).
- W_ram_ack is ignored outside BUSY.
- Lane numbering is little-endian: lane 0 = bits [7:0].

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter increments each BUSY cycle without ack.
  - At count TIMEOUT_CYCLES-1 with no ack: drop W_ram_en/W_ram_we, set W_data_ram_r_data=0, go to DONE with W_bus_err=1 for that DONE cycle.
  - Counter clears on leaving BUSY.
- Not defined: BUSY waits for ack indefinitely; W_bus_err is tied 0 and no counter logic exists.

Test Plan:
- Word load: addr=0x0000_0010, ack in first BUSY cycle, r_data=0xDEADBEEF. Expect W_ram_addr=0x0000_0004, we=0000; stall high for 2 cycles; W_data_ram_r_data=0xDEADBEEF with done=1 in cycle 3.
- Signed byte load: addr=0x13, sext=1, r_data=0x80FF_0000. Expect 0xFFFF_FF80. Repeat with sext=0: expect 0x0000_0080.
- Half store: addr=0x06, rt=0x1234_ABCD. Expect we=1100, w_data=0xABCD_ABCD, W_ram_addr=0x1.
- Misaligned word: addr=0x02. Expect W_addr_err=1, ram_en stays 0, stall=0.
- Ack delayed 5 cycles: stall stays high for 6 cycles, ram_en constant; async rst asserted mid-BUSY returns all outputs to 0 immediately.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack: DONE after 4 BUSY cycles, with W_bus_err=1 and r_data=0.
